job_dispatcher: RTL and testbench
=================================

Name: job_dispatcher

Overview:
- Upstream controller for the go/kill/done worker FSM.
- Accepts a command requesting N back-to-back worker runs and issues one single-cycle `go` per run.
- Watches each run with a timeout watchdog. On expiry, holds `kill` to abort the worker, then lets it recover to idle.
- Reports command completion, error status, and saturating success/abort statistics.

Parameters:
- TIMEOUT, 200: max cycles spent in WAIT for `done` before the run is killed; must be >= 2.
- KILL_CYCLES, 4: cycles `kill` is held high per abort; must be >= 1.
- RUNS_W, 8: width of the run-count field.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  command present.
- req_runs  in  RUNS_W  number of runs requested (0 is legal).
- req_ready  out  1  dispatcher can accept a command.
- go  out  1  one-cycle start pulse to the worker.
- kill  out  1  abort request to the worker.
- done  in  1  worker completion pulse.
- busy  out  1  command in progress.
- cmd_done  out  1  one-cycle pulse when a command finishes.
- cmd_err  out  1  valid with cmd_done; 1 if any run of the command was aborted.
- ok_cnt  out  CNT_W  total runs completed with `done`.
- abort_cnt  out  CNT_W  total runs killed.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, go=0, kill=0, busy=0, cmd_done=0, cmd_err=0, req_ready=1, ok_cnt=0, abort_cnt=0, remaining=0, timer=0.
- Outputs are Moore, decoded from the state register:
  - go=1 only in LAUNCH.
  - kill=1 only in KILL.
  - req_ready=1 only in IDLE.
  - busy = !IDLE.
- cmd_done and cmd_err are registered and pulse for exactly one cycle on the cycle after the state returns to IDLE.
- State IDLE:
  - Handshake completes when req_valid && req_ready: latch remaining=req_runs and clear the err flag.
  - If req_runs==0, stay in IDLE and pulse cmd_done (cmd_err=0) the next cycle.
  - Otherwise go to LAUNCH.
- State LAUNCH (1 cycle): timer<=0, then go to WAIT.
- State WAIT:
  - timer increments each cycle.
  - If done: ok_cnt++ and remaining--. If remaining was 1, go to IDLE (cmd_done). Otherwise go to LAUNCH.
  - Else if timer==TIMEOUT-1: go to KILL, abort_cnt++, set the err flag.
- State KILL:
  - Held exactly KILL_CYCLES cycles, using timer reused as a down-counter.
  - Then go to RECOVER.
- State RECOVER (1 cycle, kill=0):
  - Gives the worker one edge to leave abort.
  - remaining--, then go to IDLE (cmd_done, cmd_err=1) or LAUNCH.
- Simultaneous events:
  - done in the same cycle as timeout expiry: done wins, no kill.
  - done seen in KILL/RECOVER is ignored.
  - done seen in IDLE/LAUNCH is ignored and not counted.
- Counters saturate at all-ones; they never wrap.
- Back-to-back commands: a new command is accepted in the first IDLE cycle, which is the same cycle the previous cmd_done pulses.
- Reset mid-operation: everything returns to reset values next edge. kill drops immediately, and the worker is reset by the same reset.
- Timing: minimum run period without abort = worker latency + 2 cycles (LAUNCH plus the WAIT exit).

Optional Feature:
- Macro JOB_DISPATCHER_ABORT_STOP_EN.
- Defined: the first abort terminates the command. RECOVER goes straight to IDLE with cmd_done=1, cmd_err=1; remaining runs are discarded and not counted.
- Undefined: after an abort, the dispatcher continues with the remaining runs; cmd_err is still reported at the end.

Decomposition:
- Shared package dispatcher_pkg holds:
  - state encoding constants IDLE, LAUNCH, WAIT, KILL, RECOVER (3-bit);
  - default TIMEOUT, KILL_CYCLES, RUNS_W and CNT_W constants.
- One sub-module: sat_counter (parameter W; ports clk, reset, inc, value). Instantiated twice for ok_cnt and abort_cnt.

Test Plan:
- Reset then req_runs=3 with worker model (done 103 cycles after go) -> exactly 3 go pulses spaced 105 cycles apart, cmd_done with cmd_err=0, ok_cnt=3, abort_cnt=0, kill never high.
- TIMEOUT=50, req_runs=2, worker never asserts done -> per run kill high exactly 4 cycles starting 51 cycles after go; abort_cnt=2, cmd_done with cmd_err=1. With JOB_DISPATCHER_ABORT_STOP_EN: only 1 go, abort_cnt=1.
- req_runs=0 -> no go, cmd_done pulses next cycle with cmd_err=0, req_ready stays 1.
- done asserted on the exact cycle timer==TIMEOUT-1 -> no kill, ok_cnt increments, abort_cnt unchanged.
- Reset asserted for 1 cycle during KILL -> next cycle kill=0, busy=0, req_ready=1, counters=0, no cmd_done.
- Force ok_cnt to 16'hFFFE via a 2-run command after preload -> ok_cnt sticks at 16'hFFFF.

Source files
------------

// File: rtl/dispatcher_pkg.sv
// Shared state encoding and default sizing for the job dispatcher and its helpers.
package dispatcher_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    WAIT    = 3'd2,
    KILL    = 3'd3,
    RECOVER = 3'd4
  } state_e;

  localparam int DEF_TIMEOUT     = 200;
  localparam int DEF_KILL_CYCLES = 4;
  localparam int DEF_RUNS_W      = 8;
  localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/sat_counter.sv
// Statistics counter that increments on demand and sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] value
);

  logic [W-1:0] value_q;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= '0;
    end else if (inc && (value_q != {W{1'b1}})) begin
      value_q <= value_q + W'(1);
    end
  end

  assign value = value_q;

endmodule

// File: rtl/job_dispatcher.sv
// Issues N back-to-back go pulses per command, watchdogs each run and kills it on timeout.
// Build option JOB_DISPATCHER_ABORT_STOP_EN: the first abort ends the whole command.
module job_dispatcher
  import dispatcher_pkg::*;
#(
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int KILL_CYCLES = DEF_KILL_CYCLES,
  parameter int RUNS_W      = DEF_RUNS_W,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [RUNS_W-1:0] req_runs,
  output logic              req_ready,
  output logic              go,
  output logic              kill,
  input  logic              done,
  output logic              busy,
  output logic              cmd_done,
  output logic              cmd_err,
  output logic [CNT_W-1:0]  ok_cnt,
  output logic [CNT_W-1:0]  abort_cnt
);

  // One timer serves as the WAIT up-counter and the KILL down-counter.
  localparam int TMAX    = (TIMEOUT > KILL_CYCLES) ? TIMEOUT : KILL_CYCLES;
  localparam int TIMER_W = $clog2(TMAX + 1);
  localparam logic [TIMER_W-1:0] T_LAST  = TIMER_W'(TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] K_LOAD  = TIMER_W'(KILL_CYCLES - 1);
  localparam logic [RUNS_W-1:0]  ONE_RUN = RUNS_W'(1);

  state_e              state_q, state_d;
  logic [RUNS_W-1:0]   remaining_q, remaining_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                err_q, err_d;
  logic                cmd_done_q, cmd_done_d;
  logic                cmd_err_q, cmd_err_d;
  logic                ok_inc, abort_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      timer_q     <= '0;
      err_q       <= 1'b0;
      cmd_done_q  <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      timer_q     <= timer_d;
      err_q       <= err_d;
      cmd_done_q  <= cmd_done_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    timer_d     = timer_q;
    err_d       = err_q;
    cmd_done_d  = 1'b0;
    cmd_err_d   = 1'b0;
    ok_inc      = 1'b0;
    abort_inc   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          remaining_d = req_runs;
          err_d       = 1'b0;
          if (req_runs == '0) begin
            cmd_done_d = 1'b1;
          end else begin
            state_d = LAUNCH;
          end
        end
      end

      LAUNCH: begin
        timer_d = '0;
        state_d = WAIT;
      end

      WAIT: begin
        timer_d = timer_q + TIMER_W'(1);
        // A done arriving on the expiry cycle still counts as a success.
        if (done) begin
          ok_inc      = 1'b1;
          remaining_d = remaining_q - ONE_RUN;
          if (remaining_q == ONE_RUN) begin
            state_d    = IDLE;
            cmd_done_d = 1'b1;
            cmd_err_d  = err_q;
          end else begin
            state_d = LAUNCH;
          end
        end else if (timer_q == T_LAST) begin
          state_d   = KILL;
          abort_inc = 1'b1;
          err_d     = 1'b1;
          timer_d   = K_LOAD;
        end
      end

      KILL: begin
        if (timer_q == '0) begin
          state_d = RECOVER;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end

      RECOVER: begin
`ifdef JOB_DISPATCHER_ABORT_STOP_EN
        remaining_d = '0;
        state_d     = IDLE;
        cmd_done_d  = 1'b1;
        cmd_err_d   = 1'b1;
`else
        remaining_d = remaining_q - ONE_RUN;
        if (remaining_q == ONE_RUN) begin
          state_d    = IDLE;
          cmd_done_d = 1'b1;
          cmd_err_d  = 1'b1;
        end else begin
          state_d = LAUNCH;
        end
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  assign go        = (state_q == LAUNCH);
  assign kill      = (state_q == KILL);
  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign cmd_done  = cmd_done_q;
  assign cmd_err   = cmd_err_q;

  sat_counter #(.W(CNT_W)) u_ok_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ok_inc),
    .value (ok_cnt)
  );

  sat_counter #(.W(CNT_W)) u_abort_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (abort_inc),
    .value (abort_cnt)
  );

endmodule

// File: tb/tb_job_dispatcher.sv
// Directed bench: two dispatcher instances (long and short timeout) driven by a cycle-level worker model.
module tb_job_dispatcher;

  localparam int TO_A = 200;
  localparam int TO_B = 50;
  localparam int KC   = 4;
  localparam int RW   = 8;
  localparam int CW_A = 16;
  localparam int CW_B = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic [RW-1:0] req_runs = '0;
  logic          done = 1'b0;

  logic            req_ready_a, go_a, kill_a, busy_a, cmd_done_a, cmd_err_a;
  logic [CW_A-1:0] ok_cnt_a, abort_cnt_a;
  logic            req_ready_b, go_b, kill_b, busy_b, cmd_done_b, cmd_err_b;
  logic [CW_B-1:0] ok_cnt_b, abort_cnt_b;

  job_dispatcher #(.TIMEOUT(TO_A), .KILL_CYCLES(KC), .RUNS_W(RW), .CNT_W(CW_A)) dut_a (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_runs(req_runs),
    .req_ready(req_ready_a), .go(go_a), .kill(kill_a), .done(done), .busy(busy_a),
    .cmd_done(cmd_done_a), .cmd_err(cmd_err_a), .ok_cnt(ok_cnt_a), .abort_cnt(abort_cnt_a)
  );

  job_dispatcher #(.TIMEOUT(TO_B), .KILL_CYCLES(KC), .RUNS_W(RW), .CNT_W(CW_B)) dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_runs(req_runs),
    .req_ready(req_ready_b), .go(go_b), .kill(kill_b), .done(done), .busy(busy_b),
    .cmd_done(cmd_done_b), .cmd_err(cmd_err_b), .ok_cnt(ok_cnt_b), .abort_cnt(abort_cnt_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic err;
    int   ok;
    int   ab;
    int   n_go;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0, n_bad = 0, cyc = 0;
  int   wk_dly = 0, wk_cnt = 0;
  int   kill_mode = 0, kill_len = 0;
  logic kill_prev = 1'b0;
  int   last_go = -1, exp_gap = 0, go_cnt = 0, ab_exp = 0;
  bit   got_done = 1'b0;
  bit   sel = 1'b0;

  logic        go_s, kill_s, busy_s, rdy_s, cd_s, ce_s;
  logic [15:0] ok_s, ab_s;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sample();
    if (sel) begin
      go_s = go_b; kill_s = kill_b; busy_s = busy_b; rdy_s = req_ready_b;
      cd_s = cmd_done_b; ce_s = cmd_err_b;
      ok_s = {14'd0, ok_cnt_b}; ab_s = {14'd0, abort_cnt_b};
    end else begin
      go_s = go_a; kill_s = kill_a; busy_s = busy_a; rdy_s = req_ready_a;
      cd_s = cmd_done_a; ce_s = cmd_err_a;
      ok_s = ok_cnt_a; ab_s = abort_cnt_a;
    end
  endtask

  // One clock cycle: sample at the falling edge, score events, then drive the worker's done.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    sample();
    if (go_s) begin
      if (exp_gap > 0 && last_go >= 0) check("go_gap", cyc - last_go, exp_gap);
      last_go = cyc;
      go_cnt++;
    end
    if (kill_mode == 0) begin
      if (kill_s !== 1'b0) check("kill_low", kill_s, 0);
    end else if (kill_mode == 1) begin
      if (kill_s && !kill_prev) check("kill_start", cyc - last_go, TO_B + 1);
      if (!kill_s && kill_prev) check("kill_len", kill_len, KC);
    end
    kill_len  = kill_s ? kill_len + 1 : 0;
    kill_prev = kill_s;
    if (cd_s) begin
      got_done = 1'b1;
      if (sb.size() == 0) begin
        check("cmd_done_unexpected", cd_s, 0);
      end else begin
        e = sb.pop_front();
        check("cmd_err", ce_s, e.err);
        check("ok_cnt", ok_s, e.ok);
        check("abort_cnt", ab_s, e.ab);
        check("go_count", go_cnt, e.n_go);
        check("ready_on_done", rdy_s, 1);
      end
    end
    // Worker: done is high wk_dly cycles after the go cycle; wk_dly==0 means it never answers.
    done = 1'b0;
    if (wk_cnt > 0) begin
      wk_cnt--;
      if (wk_cnt == 0) done = 1'b1;
    end
    if (go_s && wk_dly > 0) wk_cnt = wk_dly;
  endtask

  task automatic issue(input int runs, input logic err, input int ok, input int ab, input int n_go);
    exp_t e;
    check("ready_at_issue", rdy_s, 1);
    e.err = err; e.ok = ok; e.ab = ab; e.n_go = n_go;
    sb.push_back(e);
    go_cnt = 0; last_go = -1; got_done = 1'b0;
    req_valid = 1'b1;
    req_runs  = RW'(runs);
    step();
    req_valid = 1'b0;
    req_runs  = '0;
  endtask

  task automatic wait_cmd(input int budget);
    int n = 0;
    while (!got_done && n < budget) begin
      step();
      n++;
    end
    check("cmd_done_seen", got_done, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    sb.delete();
    wk_cnt = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values on the long-timeout instance.
    sel = 1'b0;
    kill_mode = 0;
    do_reset();
    check("rst_ready", rdy_s, 1);
    check("rst_busy", busy_s, 0);
    check("rst_go", go_s, 0);
    check("rst_kill", kill_s, 0);
    check("rst_cmd_done", cd_s, 0);
    check("rst_cmd_err", ce_s, 0);
    check("rst_ok", ok_s, 0);
    check("rst_abort", ab_s, 0);

    // Three clean runs: worker answers 103 cycles after go, so go pulses are 105 apart.
    wk_dly = 104;
    exp_gap = 105;
    issue(3, 1'b0, 3, 0, 3);
    check("busy_in_cmd", busy_s, 1);
    check("ready_in_cmd", rdy_s, 0);
    wait_cmd(400);

    // Zero-run command accepted back-to-back in the cmd_done cycle.
    issue(0, 1'b0, 3, 0, 0);
    check("zero_done_next", got_done, 1);
    check("zero_ready", rdy_s, 1);
    check("zero_busy", busy_s, 0);
    step();
    check("zero_ready_after", rdy_s, 1);

    // done on the exact expiry cycle (timer == TIMEOUT-1) wins over the kill.
    wk_dly = TO_A;
    exp_gap = 0;
    issue(1, 1'b0, 4, 0, 1);
    wait_cmd(TO_A + 20);
    step();
    check("boundary_abort", ab_s, 0);

    // Short-timeout instance, worker never answers: every run is killed.
    sel = 1'b1;
    wk_dly = 0;
    do_reset();
    check("b_rst_ready", rdy_s, 1);
    kill_mode = 1;
    exp_gap = TO_B + KC + 2;
`ifdef JOB_DISPATCHER_ABORT_STOP_EN
    ab_exp = 1;
    issue(2, 1'b1, 0, 1, 1);
`else
    ab_exp = 2;
    issue(2, 1'b1, 0, 2, 2);
`endif
    wait_cmd(300);
    step();

    // Reset pulse in the middle of KILL.
    kill_mode = 2;
    exp_gap = 0;
    issue(1, 1'b1, 0, 0, 1);
    for (int n = 0; n < 100 && kill_s !== 1'b1; n++) step();
    check("kill_reached", kill_s, 1);
    step();
    check("abort_pre_reset", ab_s, ab_exp + 1);
    sb.delete();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_kill", kill_s, 0);
    check("mid_rst_busy", busy_s, 0);
    check("mid_rst_ready", rdy_s, 1);
    check("mid_rst_ok", ok_s, 0);
    check("mid_rst_abort", ab_s, 0);
    check("mid_rst_cmd_done", cd_s, 0);
    for (int n = 0; n < 10; n++) step();

    // Saturation with a 2-bit counter: 2 then 2 more runs leaves ok_cnt stuck at 3.
    kill_mode = 0;
    wk_dly = 3;
    exp_gap = 4;
    issue(2, 1'b0, 2, 0, 2);
    wait_cmd(50);
    issue(2, 1'b0, 3, 0, 2);
    wait_cmd(50);
    issue(1, 1'b0, 3, 0, 1);
    wait_cmd(50);
    step();
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
